fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Single-outstanding instruction fetch sequencer. Issues one request at a time
// to instruction memory, buffers the returned word together with its address,
// and presents it to decode with a valid/ready handshake. Supports PC
// redirects (branch/jump) and stops fetching permanently when the halt
// instruction is handed to decode. Only a reset leaves the halted state.
//
// Parameters
//   RESET_PC        PC loaded on reset
//   HALT_INST       instruction encoding that stops fetch once decode takes it
//
// Ports
//   clk             clock, rising-edge
//   rst             asynchronous reset, active low
//   start           level request to leave IDLE and begin fetching
//   imem_req        fetch request to instruction memory
//   imem_addr       fetch address (current pc)
//   imem_ack        imem_inst is valid for the outstanding request
//   imem_inst       fetched instruction word
//   redirect_valid  PC redirect request
//   redirect_pc     redirect target (low two bits are dropped)
//   dec_valid       dec_inst / dec_pc hold a valid instruction
//   dec_ready       decode accepts the instruction this cycle
//   dec_inst        buffered instruction
//   dec_pc          address of dec_inst
//   halted          high while halted
//   fetch_count     number of completed decode handshakes (wraps)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_INST = 32'h00100073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [63:0] dec_pc,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q,    pc_d;
    logic [31:0] inst_q,  inst_d;
    logic [63:0] pcbuf_q, pcbuf_d;
    logic [31:0] count_q, count_d;

    // Targets are forced onto a word boundary; masking keeps every input bit
    // in use rather than slicing off the two low bits.
    logic [63:0] redirect_target;
    assign redirect_target = redirect_pc & ~64'h3;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the instruction/pc buffers are reset too, because dec_inst and
    // dec_pc must read as zero during reset, not just be "don't care".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            pcbuf_q <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pcbuf_q <= pcbuf_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pcbuf_d = pcbuf_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (start) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // A redirect wins over a same-cycle ack: the returned word
                // belongs to the old path and is dropped.
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else if (imem_ack) begin
                    inst_d  = imem_inst;
                    pcbuf_d = pc_q;
                    pc_d    = pc_q + 64'd4;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (dec_ready) begin
                    count_d = count_q + 32'd1;
                end
                if (redirect_valid) begin
                    // With dec_ready low the buffered word is simply squashed;
                    // with dec_ready high it was consumed and counted above,
                    // and the redirect takes priority over a halt instruction.
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (dec_ready) begin
                    state_d = (inst_q == HALT_INST) ? S_HALT : S_REQ;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (pure functions of registered state, so reset forces them
    // immediately)
    // -------------------------------------------------------------------------
    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign dec_valid   = (state_q == S_HOLD);
    assign dec_inst    = inst_q;
    assign dec_pc      = pcbuf_q;
    assign halted      = (state_q == S_HALT);
    assign fetch_count = count_q;

endmodule
